// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel coordinates from hs/vs,
// tracks sync lock and captures the colour at a probe point.
module vga_sync_receiver #(
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490
) (
  input  logic        clk100_in,
  input  logic        rst_n_in,
  input  logic        pix_en_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [7:0]  rgb_in,
  input  logic [9:0]  probe_x_in,
  input  logic [9:0]  probe_y_in,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        de_out,
  output logic [7:0]  rgb_out,
  output logic        locked_out,
  output logic [7:0]  probe_rgb_out,
  output logic        probe_valid_out,
  output logic        err_out,
  output logic [15:0] frame_cnt_out
);
  typedef enum logic [1:0] {
    SEARCH,
    HLOCK,
    LOCKED
  } state_t;

  localparam logic [9:0]  HLAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  VACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  HSS   = 10'(H_SYNC_START);
  localparam logic [9:0]  VSS   = 10'(V_SYNC_START);
  localparam logic [10:0] HSS11 = 11'(H_SYNC_START);
  localparam logic [10:0] VSS11 = 11'(V_SYNC_START);

  state_t      r_state, w_state_n;
  logic [9:0]  r_hcnt, r_vcnt, w_hcnt_n, w_vcnt_n;
  logic        r_pend, w_pend_n;
  logic        r_hs_q, r_vs_q;
  logic        w_hs_fall, w_vs_fall, w_wrap, w_apply;
  logic        w_h_bad, w_v_bad, w_err, w_fr_inc;
  logic        w_de, w_hit;
  logic [9:0]  r_x, r_y;
  logic [7:0]  r_rgb, r_prgb;
  logic        r_de, r_pv, r_err;
  logic [15:0] r_frame;

  assign w_hs_fall = pix_en_in & ~hs_in & r_hs_q;
  assign w_vs_fall = pix_en_in & ~vs_in & r_vs_q;
  assign w_wrap    = pix_en_in & ~w_hs_fall & (r_hcnt == HLAST);
  assign w_apply   = w_wrap & (r_pend | w_vs_fall);
  assign w_h_bad   = w_hs_fall & (({1'b0, r_hcnt} + 11'd1) != HSS11);
  assign w_v_bad   = w_apply & (({1'b0, r_vcnt} + 11'd1) != VSS11);

  // Next horizontal/vertical position and pending-vsync flag
  always_comb begin
    w_hcnt_n = r_hcnt;
    w_vcnt_n = r_vcnt;
    w_pend_n = r_pend;
    if (pix_en_in) begin
      if (w_hs_fall)   w_hcnt_n = HSS;
      else if (w_wrap) w_hcnt_n = '0;
      else             w_hcnt_n = r_hcnt + 10'd1;
    end
    if (w_apply) begin
      w_vcnt_n = VSS;
      w_pend_n = 1'b0;
    end else begin
      if (w_wrap)
        w_vcnt_n = (r_vcnt == VLAST) ? '0 : r_vcnt + 10'd1;
      if (w_vs_fall) w_pend_n = 1'b1;
    end
  end

  // Lock FSM next state, error and frame-count decisions
  always_comb begin
    w_state_n = r_state;
    w_err     = 1'b0;
    w_fr_inc  = 1'b0;
    unique case (r_state)
      SEARCH: begin
        if (w_hs_fall) w_state_n = HLOCK;
      end
      HLOCK: begin
        if (w_h_bad)      w_err = 1'b1;
        else if (w_apply) w_state_n = LOCKED;
      end
      LOCKED: begin
        if (w_h_bad | w_v_bad) begin
          w_err     = 1'b1;
          w_state_n = SEARCH;
        end else if (w_apply) begin
          w_fr_inc = 1'b1;
        end
      end
      default: w_state_n = SEARCH;
    endcase
  end

  assign w_de  = (w_state_n == LOCKED) &
                 (w_hcnt_n < HACT) & (w_vcnt_n < VACT);
  assign w_hit = pix_en_in & w_de &
                 (w_hcnt_n == probe_x_in) &
                 (w_vcnt_n == probe_y_in);

  // State, counters and previous sync samples
  always_ff @(posedge clk100_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= SEARCH;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_pend  <= 1'b0;
      r_hs_q  <= 1'b1;
      r_vs_q  <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_hcnt  <= w_hcnt_n;
      r_vcnt  <= w_vcnt_n;
      r_pend  <= w_pend_n;
      if (pix_en_in) begin
        r_hs_q <= hs_in;
        r_vs_q <= vs_in;
      end
    end
  end

  // Registered outputs; pulses last exactly one clock
  always_ff @(posedge clk100_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x     <= '0;
      r_y     <= '0;
      r_rgb   <= '0;
      r_de    <= 1'b0;
      r_prgb  <= '0;
      r_pv    <= 1'b0;
      r_err   <= 1'b0;
      r_frame <= '0;
    end else begin
      r_pv  <= w_hit;
      r_err <= w_err;
      if (pix_en_in) begin
        r_x   <= w_hcnt_n;
        r_y   <= w_vcnt_n;
        r_rgb <= rgb_in;
        r_de  <= w_de;
      end
      if (w_hit)    r_prgb  <= rgb_in;
      if (w_fr_inc) r_frame <= r_frame + 16'd1;
    end
  end

  assign x_out           = r_x;
  assign y_out           = r_y;
  assign de_out          = r_de;
  assign rgb_out         = r_rgb;
  assign locked_out      = (r_state == LOCKED);
  assign probe_rgb_out   = r_prgb;
  assign probe_valid_out = r_pv;
  assign err_out         = r_err;
  assign frame_cnt_out   = r_frame;
endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_TOTAL, default 800: pixels per line.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter H_SYNC_START, default 656: pixel index at the first hs-low sample.
REQ-004 Parameter V_TOTAL, default 525: lines per frame.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_SYNC_START, default 490: line index of the first line starting after a vs fall.
REQ-007 clk100_in, input, 1: 100 MHz clock; all logic on its rising edge.
REQ-008 rst_n_in, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-009 pix_en_in, input, 1: one-cycle pixel strobe, nominally 1 of every 4 clocks; all sampling is gated by it.
REQ-010 hs_in, input, 1: horizontal sync, active low.
REQ-011 vs_in, input, 1: vertical sync, active low.
REQ-012 rgb_in, input, 8: pixel colour {r[2:0], g[2:0], b[1:0]}.
REQ-013 probe_x_in / probe_y_in, input, 10 each: capture coordinate, sampled at each pix_en_in.
REQ-014 x_out / y_out, output, 10 each: recovered pixel coordinate.
REQ-015 de_out, output, 1: visible-pixel qualifier.
REQ-016 rgb_out, output, 8: rgb_in registered alongside x_out/y_out.
REQ-017 locked_out, output, 1: high while in LOCKED.
REQ-018 probe_rgb_out, output, 8: colour captured at the probe coordinate.
REQ-019 probe_valid_out, output, 1: one-clock pulse when probe_rgb_out updates.
REQ-020 err_out, output, 1: one-clock pulse on any sync timing violation.
REQ-021 frame_cnt_out, output, 16: count of locked frames, wraps 65535->0.

Function
REQ-022 Edge detection: hs/vs fall = current sample 0 and previous pix_en_in sample 1; no edge on clocks without pix_en_in.
REQ-023 hcount (10 b): on each pix_en_in, increments; H_TOTAL-1 wraps to 0; on hs fall it loads H_SYNC_START instead.
REQ-024 vcount (10 b): steps only at hcount wrap to 0; V_TOTAL-1 wraps to 0; if vs fall pending, loads V_SYNC_START and clears pending.
REQ-025 vs fall sets the pending flag; vs fall coinciding with the wrap is applied at that same wrap.
REQ-026 FSM states: SEARCH, HLOCK, LOCKED; reset enters SEARCH.
REQ-027 SEARCH: first hs fall loads hcount and moves to HLOCK.
REQ-028 HLOCK: hs fall with hcount+1 != H_SYNC_START -> err_out pulse, reload, stay in HLOCK; pending vs applied at a wrap -> LOCKED.
REQ-029 LOCKED: hs fall mismatch, or vs applied with vcount+1 != V_SYNC_START -> err_out pulse, enter SEARCH; otherwise stay.
REQ-030 LOCKED: each correct vs application increments frame_cnt_out.
REQ-031 Simultaneous hs and vs errors produce a single err_out pulse.
REQ-032 Outputs update on the clock after the pix_en_in sample (latency 1 clock) and hold between strobes.
REQ-033 de_out = locked and hcount < H_ACTIVE and vcount < V_ACTIVE, for the registered coordinate.
REQ-034 Probe: when de_out condition holds and (hcount, vcount) == (probe_x_in, probe_y_in), latch rgb_in into probe_rgb_out and pulse probe_valid_out together with the coordinate update.
REQ-035 Outside LOCKED: de_out=0, probe never fires, x_out/y_out still track the counters.

Reset
REQ-036 rst_n_in low asynchronously clears all counters and outputs to 0, the pending flag to 0, and the previous sync samples to 1; state returns to SEARCH.
REQ-037 Reset mid-frame discards lock; relock requires a fresh hs fall and vs fall.

Verification
REQ-038 Drive 640x480@60 stream (800x525, hs low pixels 656-751, vs low lines 490-491), pix_en every 4th clock -> locked_out high after the first vs, err_out never pulses, frame_cnt_out +1 per frame.
REQ-039 Locked; rgb_in = x[7:0] pattern; probe (100,50) -> probe_valid_out pulses once per frame, probe_rgb_out=8'h64.
REQ-040 Locked; one line 801 pixels -> err_out single pulse, locked_out low, relock after the next correct frame.
REQ-041 Locked; vs fall on line 495 -> err_out pulse, SEARCH, de_out stays 0 until relocked.
REQ-042 Mid-frame rst_n_in low 3 clocks -> all outputs 0 immediately, no err_out; relocks after the next vs.
REQ-043 Stream with pix_en_in stalled 10 clocks mid-line -> counters hold, no error, x_out continuous.
